// File: rtl/md_k2h_record_packer.sv
// Packs REC_WIDTH particle records into AXIS_TDATA_WIDTH k2h beats, closing beats on the
// record-level last flag or a full beat, and closing packets on last or a programmable beat limit.
module md_k2h_record_packer #(
    parameter int AXIS_TDATA_WIDTH      = 512,
    parameter int REC_WIDTH             = 192,
    parameter int STREAMING_TDEST_WIDTH = 16
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic [REC_WIDTH-1:0]               rec_tdata,
    input  logic                               rec_tvalid,
    input  logic                               rec_tlast,
    output logic                               rec_tready,
    input  logic [STREAMING_TDEST_WIDTH-1:0]   cfg_dest,
    input  logic [15:0]                        cfg_max_beats,
    output logic [AXIS_TDATA_WIDTH-1:0]        M_AXIS_k2h_tdata,
    output logic [AXIS_TDATA_WIDTH/8-1:0]      M_AXIS_k2h_tkeep,
    output logic                               M_AXIS_k2h_tvalid,
    output logic                               M_AXIS_k2h_tlast,
    output logic [STREAMING_TDEST_WIDTH-1:0]   M_AXIS_k2h_tdest,
    input  logic                               M_AXIS_k2h_tready,
    output logic [31:0]                        frames_sent,
    output logic                               busy
);

    localparam int RECS_PER_BEAT = AXIS_TDATA_WIDTH / REC_WIDTH;
    localparam int REC_BYTES     = REC_WIDTH / 8;
    localparam int ACC_W         = RECS_PER_BEAT * REC_WIDTH;
    localparam int SLOT_W        = (RECS_PER_BEAT > 1) ? $clog2(RECS_PER_BEAT) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RECS_PER_BEAT - 1);

    logic [ACC_W-1:0]                 r_acc;
    logic [SLOT_W-1:0]                r_slot;
    logic [15:0]                      r_beat_cnt;
    logic [STREAMING_TDEST_WIDTH-1:0] r_pkt_dest;
    logic [AXIS_TDATA_WIDTH-1:0]      r_tdata;
    logic [AXIS_TDATA_WIDTH/8-1:0]    r_tkeep;
    logic                             r_tvalid;
    logic                             r_tlast;
    logic [STREAMING_TDEST_WIDTH-1:0] r_tdest;
    logic [31:0]                      r_frames;

    logic                             w_accept;
    logic                             w_close;
    logic                             w_first;
    logic [STREAMING_TDEST_WIDTH-1:0] w_dest;
    logic [16:0]                      w_beat_num;
    logic                             w_limit_hit;
    logic                             w_end_pkt;
    logic [ACC_W-1:0]                 w_acc_merged;
    logic [AXIS_TDATA_WIDTH-1:0]      w_tdata_next;
    logic [AXIS_TDATA_WIDTH/8-1:0]    w_tkeep_next;

    assign rec_tready  = !r_tvalid | M_AXIS_k2h_tready;
    assign w_accept    = rec_tvalid & rec_tready;
    assign w_close     = w_accept & (rec_tlast | (r_slot == LAST_SLOT));
    assign w_first     = (r_slot == '0) && (r_beat_cnt == '0);
    // The packet's first record may close its own beat, so bypass the latch in that case.
    assign w_dest      = w_first ? cfg_dest : r_pkt_dest;
    assign w_beat_num  = {1'b0, r_beat_cnt} + 17'd1;
    assign w_limit_hit = (cfg_max_beats != '0) && (w_beat_num >= {1'b0, cfg_max_beats});
    assign w_end_pkt   = rec_tlast | w_limit_hit;

    always_comb begin
        w_acc_merged = r_acc;
        w_tkeep_next = '0;
        w_tdata_next = '0;
        for (int unsigned k = 0; k < RECS_PER_BEAT; k++) begin
            if (k == 32'(r_slot))
                w_acc_merged[k*REC_WIDTH +: REC_WIDTH] = rec_tdata;
            if (k <= 32'(r_slot))
                w_tkeep_next[k*REC_BYTES +: REC_BYTES] = {REC_BYTES{1'b1}};
        end
        w_tdata_next[ACC_W-1:0] = w_acc_merged;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_acc      <= '0;
            r_slot     <= '0;
            r_beat_cnt <= '0;
            r_pkt_dest <= '0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdest    <= '0;
            r_frames   <= '0;
        end else begin
            if (w_accept && w_first)
                r_pkt_dest <= cfg_dest;

            if (w_close) begin
                r_acc   <= '0;
                r_slot  <= '0;
                r_tdata <= w_tdata_next;
                r_tkeep <= w_tkeep_next;
                r_tlast <= w_end_pkt;
                r_tdest <= w_dest;
                if (w_end_pkt)
                    r_beat_cnt <= '0;
                else if (r_beat_cnt != '1)
                    r_beat_cnt <= r_beat_cnt + 16'd1;
            end else if (w_accept) begin
                r_acc  <= w_acc_merged;
                r_slot <= r_slot + SLOT_W'(1);
            end

            if (w_close)
                r_tvalid <= 1'b1;
            else if (M_AXIS_k2h_tready)
                r_tvalid <= 1'b0;

            if (r_tvalid && M_AXIS_k2h_tready && r_tlast)
                r_frames <= r_frames + 32'd1;
        end
    end

    assign M_AXIS_k2h_tdata  = r_tdata;
    assign M_AXIS_k2h_tkeep  = r_tkeep;
    assign M_AXIS_k2h_tvalid = r_tvalid;
    assign M_AXIS_k2h_tlast  = r_tlast;
    assign M_AXIS_k2h_tdest  = r_tdest;
    assign frames_sent       = r_frames;
    assign busy              = (r_slot != '0) | r_tvalid | (r_beat_cnt != '0);

endmodule

// File: tb/tb_md_k2h_record_packer.sv
// Directed bench for md_k2h_record_packer: a cycle table for streaming cases plus
// hand-written sequences for backpressure, tdest latching and mid-frame reset.
module tb_md_k2h_record_packer;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n;
    logic [191:0] rec_tdata;
    logic         rec_tvalid;
    logic         rec_tlast;
    logic         rec_tready;
    logic [15:0]  cfg_dest;
    logic [15:0]  cfg_max_beats;
    logic [511:0] M_AXIS_k2h_tdata;
    logic [63:0]  M_AXIS_k2h_tkeep;
    logic         M_AXIS_k2h_tvalid;
    logic         M_AXIS_k2h_tlast;
    logic [15:0]  M_AXIS_k2h_tdest;
    logic         M_AXIS_k2h_tready;
    logic [31:0]  frames_sent;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    md_k2h_record_packer #(
        .AXIS_TDATA_WIDTH(512),
        .REC_WIDTH(192),
        .STREAMING_TDEST_WIDTH(16)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .rec_tdata(rec_tdata),
        .rec_tvalid(rec_tvalid),
        .rec_tlast(rec_tlast),
        .rec_tready(rec_tready),
        .cfg_dest(cfg_dest),
        .cfg_max_beats(cfg_max_beats),
        .M_AXIS_k2h_tdata(M_AXIS_k2h_tdata),
        .M_AXIS_k2h_tkeep(M_AXIS_k2h_tkeep),
        .M_AXIS_k2h_tvalid(M_AXIS_k2h_tvalid),
        .M_AXIS_k2h_tlast(M_AXIS_k2h_tlast),
        .M_AXIS_k2h_tdest(M_AXIS_k2h_tdest),
        .M_AXIS_k2h_tready(M_AXIS_k2h_tready),
        .frames_sent(frames_sent),
        .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    // Record id n carries a recognisable byte pattern; id 0 stands for an empty slot.
    function automatic logic [191:0] rec(int id);
        logic [7:0] b;
        b = id[7:0];
        if (id == 0) return '0;
        return {8{b, 16'hA5C3}};
    endfunction

    function automatic logic [511:0] beat_data(int hi, int lo);
        logic [511:0] d;
        d = '0;
        d[191:0]   = rec(lo);
        d[383:192] = rec(hi);
        return d;
    endfunction

    task automatic chk(string name, logic [511:0] got, logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_beat(string name, int hi, int lo, logic last, logic [15:0] dest);
        logic [63:0] keep;
        keep = (hi != 0) ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_00FF_FFFF;
        chk({name, ".tvalid"}, 512'(M_AXIS_k2h_tvalid), 512'(1'b1));
        chk({name, ".tdata"},  M_AXIS_k2h_tdata, beat_data(hi, lo));
        chk({name, ".tkeep"},  512'(M_AXIS_k2h_tkeep), 512'(keep));
        chk({name, ".tlast"},  512'(M_AXIS_k2h_tlast), 512'(last));
        chk({name, ".tdest"},  512'(M_AXIS_k2h_tdest), 512'(dest));
    endtask

    task automatic put(int id, logic last);
        rec_tvalid = (id != 0);
        rec_tdata  = rec(id);
        rec_tlast  = last;
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    typedef struct {
        int          id;      // record driven this cycle, 0 = idle
        logic        last;
        logic [15:0] maxb;
        logic        ev;      // expected tvalid after the edge
        int          ehi;
        int          elo;
        logic        elast;
        int          efr;
        logic        ebusy;
    } vec_t;

    vec_t tbl[20];

    initial begin
        // A..D, then a 3-record frame, then a 10-record frame with a 2-beat packet limit.
        tbl[0]  = '{1,  1'b0, 16'd0, 1'b0, 0,  0,  1'b0, 0, 1'b1};
        tbl[1]  = '{2,  1'b0, 16'd0, 1'b1, 2,  1,  1'b0, 0, 1'b1};
        tbl[2]  = '{3,  1'b0, 16'd0, 1'b0, 0,  0,  1'b0, 0, 1'b1};
        tbl[3]  = '{4,  1'b1, 16'd0, 1'b1, 4,  3,  1'b1, 0, 1'b1};
        tbl[4]  = '{0,  1'b0, 16'd0, 1'b0, 0,  0,  1'b0, 1, 1'b0};
        tbl[5]  = '{5,  1'b0, 16'd0, 1'b0, 0,  0,  1'b0, 1, 1'b1};
        tbl[6]  = '{6,  1'b0, 16'd0, 1'b1, 6,  5,  1'b0, 1, 1'b1};
        tbl[7]  = '{7,  1'b1, 16'd0, 1'b1, 0,  7,  1'b1, 1, 1'b1};
        tbl[8]  = '{0,  1'b0, 16'd0, 1'b0, 0,  0,  1'b0, 2, 1'b0};
        tbl[9]  = '{11, 1'b0, 16'd2, 1'b0, 0,  0,  1'b0, 2, 1'b1};
        tbl[10] = '{12, 1'b0, 16'd2, 1'b1, 12, 11, 1'b0, 2, 1'b1};
        tbl[11] = '{13, 1'b0, 16'd2, 1'b0, 0,  0,  1'b0, 2, 1'b1};
        tbl[12] = '{14, 1'b0, 16'd2, 1'b1, 14, 13, 1'b1, 2, 1'b1};
        tbl[13] = '{15, 1'b0, 16'd2, 1'b0, 0,  0,  1'b0, 3, 1'b1};
        tbl[14] = '{16, 1'b0, 16'd2, 1'b1, 16, 15, 1'b0, 3, 1'b1};
        tbl[15] = '{17, 1'b0, 16'd2, 1'b0, 0,  0,  1'b0, 3, 1'b1};
        tbl[16] = '{18, 1'b0, 16'd2, 1'b1, 18, 17, 1'b1, 3, 1'b1};
        tbl[17] = '{19, 1'b0, 16'd2, 1'b0, 0,  0,  1'b0, 4, 1'b1};
        tbl[18] = '{20, 1'b1, 16'd2, 1'b1, 20, 19, 1'b1, 4, 1'b1};
        tbl[19] = '{0,  1'b0, 16'd2, 1'b0, 0,  0,  1'b0, 5, 1'b0};

        ap_rst_n          = 1'b0;
        cfg_dest          = 16'h0005;
        cfg_max_beats     = 16'd0;
        M_AXIS_k2h_tready = 1'b1;
        put(0, 1'b0);
        cyc();
        cyc();

        chk("rst.tvalid", 512'(M_AXIS_k2h_tvalid), 512'(1'b0));
        chk("rst.tlast",  512'(M_AXIS_k2h_tlast), 512'(1'b0));
        chk("rst.tdata",  M_AXIS_k2h_tdata, 512'd0);
        chk("rst.tkeep",  512'(M_AXIS_k2h_tkeep), 512'd0);
        chk("rst.tdest",  512'(M_AXIS_k2h_tdest), 512'd0);
        chk("rst.frames", 512'(frames_sent), 512'd0);
        chk("rst.busy",   512'(busy), 512'(1'b0));
        ap_rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            string nm;
            nm = $sformatf("tbl%0d", i);
            cfg_max_beats = tbl[i].maxb;
            put(tbl[i].id, tbl[i].last);
            #1;
            chk({nm, ".rec_tready"}, 512'(rec_tready), 512'(1'b1));
            cyc();
            chk({nm, ".tvalid"}, 512'(M_AXIS_k2h_tvalid), 512'(tbl[i].ev));
            if (tbl[i].ev)
                chk_beat(nm, tbl[i].ehi, tbl[i].elo, tbl[i].elast, 16'h0005);
            chk({nm, ".frames"}, 512'(frames_sent), 512'(tbl[i].efr));
            chk({nm, ".busy"},   512'(busy), 512'(tbl[i].ebusy));
        end

        // Backpressure: beat held stable for 8 cycles, then released without loss.
        put(0, 1'b0);
        cfg_max_beats = 16'd0;
        ap_rst_n = 1'b0;
        cyc();
        ap_rst_n = 1'b1;
        M_AXIS_k2h_tready = 1'b0;
        put(31, 1'b0);
        #1;
        chk("bp.ready_empty", 512'(rec_tready), 512'(1'b1));
        cyc();
        put(32, 1'b0);
        cyc();
        chk_beat("bp.first", 32, 31, 1'b0, 16'h0005);
        put(33, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("bp.stall%0d.rec_tready", i), 512'(rec_tready), 512'(1'b0));
            cyc();
            chk_beat($sformatf("bp.stall%0d", i), 32, 31, 1'b0, 16'h0005);
        end
        M_AXIS_k2h_tready = 1'b1;
        #1;
        chk("bp.release.rec_tready", 512'(rec_tready), 512'(1'b1));
        cyc();
        chk("bp.drained.tvalid", 512'(M_AXIS_k2h_tvalid), 512'(1'b0));
        put(34, 1'b1);
        cyc();
        chk_beat("bp.second", 34, 33, 1'b1, 16'h0005);
        put(0, 1'b0);
        cyc();
        chk("bp.frames", 512'(frames_sent), 512'd1);

        // tdest sampled at the first record of a packet only.
        put(41, 1'b0);
        cyc();
        cfg_dest = 16'h0009;
        put(42, 1'b0);
        cyc();
        chk_beat("dest.b1", 42, 41, 1'b0, 16'h0005);
        put(43, 1'b0);
        cyc();
        put(44, 1'b1);
        cyc();
        chk_beat("dest.b2", 44, 43, 1'b1, 16'h0005);
        put(45, 1'b0);
        cyc();
        put(46, 1'b1);
        cyc();
        chk_beat("dest.next", 46, 45, 1'b1, 16'h0009);
        put(0, 1'b0);
        cyc();
        chk("dest.frames", 512'(frames_sent), 512'd3);

        // Reset mid-beat drops the partial record.
        put(51, 1'b0);
        cyc();
        chk("rst2.busy_before", 512'(busy), 512'(1'b1));
        put(0, 1'b0);
        ap_rst_n = 1'b0;
        cyc();
        ap_rst_n = 1'b1;
        chk("rst2.tvalid", 512'(M_AXIS_k2h_tvalid), 512'(1'b0));
        chk("rst2.busy",   512'(busy), 512'(1'b0));
        chk("rst2.frames", 512'(frames_sent), 512'd0);
        put(52, 1'b0);
        cyc();
        chk("rst2.no_early_beat", 512'(M_AXIS_k2h_tvalid), 512'(1'b0));
        put(53, 1'b1);
        cyc();
        chk_beat("rst2.beat", 53, 52, 1'b1, 16'h0009);
        put(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rst2.idle%0d.tvalid", i), 512'(M_AXIS_k2h_tvalid), 512'(1'b0));
        end
        chk("rst2.frames_end", 512'(frames_sent), 512'd1);
        chk("rst2.busy_end",   512'(busy), 512'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
